// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction fetch into a small
// PC-tagged FIFO, presented to decode over valid/ready.
// Ports:
//   clock, reset          : rising-edge clock, sync active-high reset
//   redirect_valid/pc     : flush queue and restart fetch at redirect_pc
//   imem_req/addr         : one-cycle read request pulse and address
//   imem_rvalid/rdata     : read return (>=1 cycle after request)
//   instr_valid/data/pc   : queue head towards decode
//   instr_ready           : decode takes the head this cycle
module instr_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic              push;
  logic              pop;

  // fetch_pc stays at the outstanding address until its data returns,
  // so it doubles as the tag of the word being pushed.
  assign push = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count != '0);
  assign instr_data = data_q[rd_ptr];
  assign instr_pc = pc_q[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      imem_req <= 1'b0;
      // A request still in flight must be swallowed when it returns.
      state <= (state != IDLE && !imem_rvalid) ? DISCARD : IDLE;
    end else begin
      imem_req <= 1'b0;
      unique case (state)
        IDLE: begin
          // In IDLE nothing is outstanding, so count alone bounds space.
          if (count < FULL) begin
            imem_req <= 1'b1;
            imem_addr <= fetch_pc;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr] <= fetch_pc;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed scenarios plus randomized traffic
// against a queue-based fetch model and a latency-driven memory.
module tb_instr_prefetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int mem_left = 0;
  logic mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] salt = '0;

  logic [63:0] q[$];
  logic        live = 1'b0;
  logic [31:0] live_addr = '0;
  logic [31:0] exp_fetch = '0;
  logic [31:0] req_log[$];
  logic [31:0] req_exp[$];
  int          req_cyc[$];
  logic [63:0] pop_log[$];
  int          overlap = 0;
  logic        new_req = 1'b0;

  instr_prefetch_queue #(
    .ADDR_W(32),
    .DATA_W(32),
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Advance one cycle: update the model for the coming edge, then
  // let memory produce this cycle's return.
  task automatic tick();
    new_req = 1'b0;
    if (imem_req === 1'b1) begin
      new_req = 1'b1;
      req_log.push_back(imem_addr);
      req_exp.push_back(exp_fetch);
      req_cyc.push_back(cyc);
      if (mem_busy) overlap++;
      mem_busy = 1'b1;
      mem_left = lat;
      mem_addr = imem_addr;
    end
    if (!reset && !redirect_valid && instr_valid === 1'b1 && instr_ready)
      pop_log.push_back({instr_pc, instr_data});
    if (reset) begin
      q.delete();
      live = 1'b0;
      exp_fetch = 32'h0;
    end else if (redirect_valid) begin
      q.delete();
      live = 1'b0;
      exp_fetch = redirect_pc;
    end else begin
      if (instr_ready && q.size() != 0) void'(q.pop_front());
      if (imem_rvalid && live) begin
        q.push_back({live_addr, imem_rdata});
        live = 1'b0;
        exp_fetch = live_addr + 32'd4;
      end
      if (imem_req === 1'b1) begin
        live = 1'b1;
        live_addr = imem_addr;
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (mem_busy) begin
      mem_left--;
      if (mem_left <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = data_of(mem_addr);
        mem_busy = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    req_log.delete();
    req_exp.delete();
    req_cyc.delete();
    pop_log.delete();
    overlap = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got=%b want=0", imem_req);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b want=0", instr_valid);
    end
    checks++;
    if (instr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", instr_data);
    end
    checks++;
    if (instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc got=%h want=0", instr_pc);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req got=%b/%h want=1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr[%0d] got=%0d reqs want=%h", i, req_log.size(), 32'(4 * i));
      end
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== {32'(4 * i), data_of(32'(4 * i))}) begin
        errors++;
        $display("FAIL stream_pop[%0d] got=%0d pops want pc=%h", i, pop_log.size(), 32'(4 * i));
      end
    end
    checks++;
    if (req_cyc.size() < 4 || req_cyc[1] - req_cyc[0] != 3 || req_cyc[3] - req_cyc[2] != 3) begin
      errors++;
      $display("FAIL stream_rate got=%0d reqs want period 3", req_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 2;
    instr_ready = 1'b0;
    repeat (30) tick();
    checks++;
    if (req_log.size() != 4) begin
      errors++;
      $display("FAIL bp_req_count got=%0d want=4", req_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL bp_addr[%0d] want=%h", i, 32'(4 * i));
      end
    end
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_hold got req=%b v=%b pc=%h want 0/1/0", imem_req, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    repeat (30) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== {32'(4 * i), data_of(32'(4 * i))}) begin
        errors++;
        $display("FAIL bp_drain[%0d] got=%0d pops want pc=%h", i, pop_log.size(), 32'(4 * i));
      end
    end
    checks++;
    if (req_log.size() < 5 || req_log[4] !== 32'h10) begin
      errors++;
      $display("FAIL bp_resume got=%0d reqs want addr 10", req_log.size());
    end
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    do_reset();
    lat = 3;
    instr_ready = 1'b0;
    while (req_log.size() < 2 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL rw_setup got v=%b pc=%h want 1/0", instr_valid, instr_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_flush got=%b want=0", instr_valid);
    end
    n = 0;
    while (imem_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rw_next_addr got=%b/%h want=1/100", imem_req, imem_addr);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_stale_drop got=%b want=0", instr_valid);
    end
    instr_ready = 1'b1;
    repeat (15) tick();
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== {32'h100, data_of(32'h100)}) begin
      errors++;
      $display("FAIL rw_first_pc got=%0d pops want pc=100", pop_log.size());
    end
  endtask

  task automatic test_redirect_rvalid();
    int n = 0;
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    while (!(imem_rvalid && instr_valid === 1'b1) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (!(imem_rvalid && instr_valid === 1'b1)) begin
      errors++;
      $display("FAIL rr_setup got v=%b want=1 with return", instr_valid);
    end
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_no_push got=%b want=0", instr_valid);
    end
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rr_next_addr got=%b/%h want=1/200", imem_req, imem_addr);
    end
    instr_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== {32'h200, data_of(32'h200)}) begin
      errors++;
      $display("FAIL rr_first_pc got=%0d pops want pc=200", pop_log.size());
    end
  endtask

  task automatic test_wrap_pushpop();
    int n = 0;
    logic [31:0] a;
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    while (!(q.size() == 3 && imem_rvalid) && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (!(q.size() == 3 && imem_rvalid)) begin
      errors++;
      $display("FAIL wp_setup got=%0d entries want=3 with return", q.size());
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wp_head got v=%b pc=%h want 1/fffffffc", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    repeat (30) tick();
    a = 32'hFFFF_FFF8;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== {a, data_of(a)}) begin
        errors++;
        $display("FAIL wp_order[%0d] got=%0d pops want pc=%h", i, pop_log.size(), a);
      end
      checks++;
      if (req_log.size() <= i || req_log[i] !== a) begin
        errors++;
        $display("FAIL wp_addr[%0d] got=%0d reqs want=%h", i, req_log.size(), a);
      end
      a = a + 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int base;
    do_reset();
    lat = 3;
    instr_ready = 1'b1;
    while (req_log.size() < 3 && n < 60) begin
      tick();
      n++;
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    req_log.delete();
    base = pop_log.size();
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_late_push got=%b want=0", instr_valid);
    end
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_restart got=%b/%h want=1/0", imem_req, imem_addr);
    end
    repeat (12) tick();
    checks++;
    if (pop_log.size() <= base || pop_log[base] !== {32'h0, data_of(32'h0)}) begin
      errors++;
      $display("FAIL rm_first_pop got=%0d pops want pc=0", pop_log.size() - base);
    end
  endtask

  task automatic test_random();
    int bad_head = 0;
    int bad_req = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 99) < (((i / 150) % 2) != 0 ? 15 : 80));
      lat = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom) & 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (instr_valid !== (q.size() != 0) || q.size() > 4 ||
          (q.size() != 0 && {instr_pc, instr_data} !== q[0])) begin
        errors++;
        bad_head++;
        if (bad_head < 5)
          $display("FAIL rnd_head cyc=%0d got v=%b pc=%h want n=%0d pc=%h",
                   cyc, instr_valid, instr_pc, q.size(),
                   (q.size() != 0) ? q[0][63:32] : 32'h0);
      end
      if (new_req) begin
        checks++;
        if (req_log[$] !== req_exp[$]) begin
          errors++;
          bad_req++;
          if (bad_req < 5)
            $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, req_log[$], req_exp[$]);
        end
      end
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL rnd_outstanding got=%0d overlaps want=0", overlap);
    end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap_pushpop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
